// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds PC and IR, runs the instruction-memory read
// handshake with a timeout, and loads the next PC from one of four sources.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] IR,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic        align_fault
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ir, w_ir_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_align, w_align_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_src;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    case (PCSrc)
      2'b00:   w_src = w_pc_plus4;
      2'b01:   w_src = branch_target;
      2'b10:   w_src = jump_target;
      default: w_src = jr_target;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_fetch_pc_nxt = r_fetch_pc;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_align_nxt    = r_align;
    case (r_state)
      S_IDLE: begin
        // The PC load and the fetch start share an edge, so WAIT sees the new PC.
        if (pc_write) begin
          w_pc_nxt = {w_src[31:2], 2'b00};
          if (w_src[1:0] != 2'b00) w_align_nxt = 1'b1;
        end
        if (fetch_start) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_ir_nxt       = imem_rdata;
          w_fetch_pc_nxt = r_pc;
          w_pc_nxt       = w_pc_plus4;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_pc       <= RESET_PC;
      r_ir       <= 32'd0;
      r_fetch_pc <= 32'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_align    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_align    <= w_align_nxt;
    end
  end

  assign imem_req    = (r_state == S_WAIT);
  assign busy        = (r_state == S_WAIT);
  assign imem_addr   = r_pc;
  assign IR          = r_ir;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_pc    = r_fetch_pc;
  assign fetch_done  = r_done;
  assign fetch_err   = r_err;
  assign align_fault = r_align;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch latency, PC sources, alignment,
// timeout, reset mid-fetch and PC wrap-around.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_start;
  logic        pc_write;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] IR, pc_out, pc_plus4, fetch_pc;
  logic        busy, fetch_done, fetch_err, align_fault;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .fetch_start(fetch_start), .pc_write(pc_write),
    .PCSrc(PCSrc), .branch_target(branch_target), .jump_target(jump_target),
    .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .IR(IR), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .fetch_pc(fetch_pc), .busy(busy),
    .fetch_done(fetch_done), .fetch_err(fetch_err), .align_fault(align_fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] data, input logic [31:0] addr);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    chk("fetch_done", {31'd0, fetch_done}, 32'd1);
    chk("fetch_ir", IR, data);
    chk("fetch_pc_out", pc_out, addr + 32'd4);
    tick();
  endtask

  initial begin
    int n;
    RST = 1'b0; fetch_start = 1'b0; pc_write = 1'b0; PCSrc = 2'b00;
    branch_target = '0; jump_target = '0; jr_target = '0;
    imem_rdata = '0; imem_ack = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_flags", {28'd0, busy, fetch_done, fetch_err, align_fault}, 32'd0);
    RST = 1'b1;

    // Single minimum-latency fetch
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    imem_ack = 1'b0;
    chk("t1_done", {31'd0, fetch_done}, 32'd1);
    chk("t1_req_low", {31'd0, imem_req}, 32'd0);
    chk("t1_ir", IR, 32'h0800_0010);
    chk("t1_pc", pc_out, 32'd4);
    chk("t1_fetch_pc", fetch_pc, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, fetch_done}, 32'd0);

    // Jump load then fetch with three wait cycles
    pc_write = 1'b1; PCSrc = 2'b10; jump_target = 32'h0000_0040;
    tick();
    pc_write = 1'b0;
    chk("t2_pc", pc_out, 32'h40);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_addr", imem_addr, 32'h40);
      chk("t2_wait_done", {31'd0, fetch_done}, 32'd0);
      tick();
    end
    chk("t2_ack_addr", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("t2_done", {31'd0, fetch_done}, 32'd1);
    chk("t2_pc_after", pc_out, 32'h44);
    chk("t2_fetch_pc", fetch_pc, 32'h40);

    // Simultaneous start + write (also back-to-back with previous done)
    fetch_start = 1'b1; pc_write = 1'b1; PCSrc = 2'b01; branch_target = 32'h100;
    tick();
    fetch_start = 1'b0; PCSrc = 2'b10;
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    pc_write = 1'b0;
    chk("t3_pc_hold", pc_out, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    tick();
    imem_ack = 1'b0;
    chk("t3_pc_after", pc_out, 32'h104);
    chk("t3_ir", IR, 32'hAAAA_5555);
    tick();

    // Misaligned register-target load
    pc_write = 1'b1; PCSrc = 2'b11; jr_target = 32'h0000_0203;
    tick();
    pc_write = 1'b0;
    chk("t4_pc", pc_out, 32'h200);
    chk("t4_align", {31'd0, align_fault}, 32'd1);
    for (int i = 0; i < 10; i++)
      do_fetch(32'hC000_0000 + 32'(i), 32'h200 + 32'(4 * i));
    chk("t4_align_sticky", {31'd0, align_fault}, 32'd1);
    chk("t4_pc_end", pc_out, 32'h228);

    // Timeout with no ack
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      tick();
    end
    chk("t5_req_cycles", 32'(n), 32'd8);
    chk("t5_err", {31'd0, fetch_err}, 32'd1);
    chk("t5_no_done", {31'd0, fetch_done}, 32'd0);
    chk("t5_pc", pc_out, 32'h228);
    chk("t5_ir", IR, 32'hC000_0009);
    tick();
    chk("t5_err_pulse", {31'd0, fetch_err}, 32'd0);
    do_fetch(32'h0BAD_F00D, 32'h228);

    // Reset during WAIT, late ack ignored
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("t6_req_low", {31'd0, imem_req}, 32'd0);
    chk("t6_pc", pc_out, 32'd0);
    chk("t6_align_clr", {31'd0, align_fault}, 32'd0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("t6_ir", IR, 32'd0);
    chk("t6_no_done", {31'd0, fetch_done}, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    // PC wrap-around
    pc_write = 1'b1; PCSrc = 2'b01; branch_target = 32'hFFFF_FFFC;
    tick();
    pc_write = 1'b0;
    chk("t7_pc", pc_out, 32'hFFFF_FFFC);
    chk("t7_plus4", pc_plus4, 32'd0);
    do_fetch(32'h0000_0001, 32'hFFFF_FFFC);
    chk("t7_wrap", pc_out, 32'd0);
    chk("t7_fetch_pc", fetch_pc, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the multicycle CPU. It holds the program counter and instruction register, runs the instruction-memory read handshake when the control FSM requests a fetch, and advances PC by 4 on every completed fetch. On control-FSM request it loads the next PC from one of four sources: PC+4, branch target, jump target, or register target. `IR[25:0]` and `pc_plus4[31:28]` feed the jump-target builder, whose 32-bit result returns here on `jump_target`.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `TIMEOUT`, 255: cycles to wait for `imem_ack` before the fetch is aborted (1..255).

- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `fetch_start`  in  1  control FSM requests a fetch at the current PC.
- `pc_write`  in  1  load PC from the source selected by `PCSrc`.
- `PCSrc`  in  2  00 = PC+4, 01 = `branch_target`, 10 = `jump_target`, 11 = `jr_target`.
- `branch_target`, `jump_target`, `jr_target`  in  32 each  candidate next-PC values.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  read address; equals `pc_out` while `imem_req` = 1.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` = 1.
- `imem_ack`  in  1  memory completion, sampled only while `imem_req` = 1.
- `IR`  out  32  latched instruction.
- `pc_out`  out  32  current PC.
- `pc_plus4`  out  32  `pc_out` + 4, combinational, modulo 2^32.
- `fetch_pc`  out  32  address of the instruction currently held in `IR`.
- `busy`  out  1  a fetch is in progress.
- `fetch_done`  out  1  one-cycle pulse: `IR` holds the new instruction.
- `fetch_err`  out  1  one-cycle pulse: fetch aborted by timeout.
- `align_fault`  out  1  sticky: a non-word-aligned PC load was attempted.

## Operation
- Two states: IDLE and WAIT.
- **Reset.** When `RST` = 0 at a rising edge:
  - state = IDLE, PC = `RESET_PC`, `IR` = 0, `fetch_pc` = 0.
  - `imem_req`, `busy`, `fetch_done`, `fetch_err`, `align_fault` = 0; timeout counter = 0.
  - Reset overrides everything, including a fetch in WAIT. A late `imem_ack` after reset is ignored.
- **IDLE.**
  - `fetch_start` = 1: go to WAIT and clear the counter.
  - `pc_write` = 1: load PC from the source selected by `PCSrc`.
  - Both in the same cycle: the PC load happens first, so WAIT fetches from the new PC.
  - `imem_ack` is ignored in IDLE.
- **WAIT.**
  - Outputs: `imem_req` = 1, `busy` = 1, `imem_addr` = PC.
  - `imem_ack` = 1 at an edge: `IR` = `imem_rdata`, `fetch_pc` = PC, PC = PC + 4, go to IDLE, pulse `fetch_done` in the next cycle.
  - Otherwise the counter increments. If the counter equals `TIMEOUT - 1` with no ack: go to IDLE, pulse `fetch_err` next cycle; PC and `IR` are unchanged.
  - `fetch_start` and `pc_write` are ignored in WAIT.
- **PC load alignment.** If the selected source has bits [1:0] ≠ 00:
  - PC loads `{src[31:2], 2'b00}`.
  - `align_fault` sets and stays set until reset.
- **Wrap-around.** PC + 4 from 32'hFFFF_FFFC wraps to 0; `fetch_done` still pulses.

## Timing
- Minimum fetch: `fetch_start` in cycle 0 (IDLE), `imem_req` high in cycle 1; ack in cycle 1 gives `fetch_done` and the new `IR`/PC in cycle 2.
- Ack in cycle k (k ≥ 1): `fetch_done` in cycle k+1, `imem_req` low in cycle k+1.
- Back-to-back fetches: `fetch_start` accepted in the `fetch_done` cycle; the next request is issued the following cycle.
- `pc_write` in IDLE: new `pc_out` visible in the next cycle.
- `fetch_done` and `fetch_err` are registered and never both high.
- Timeout: with no ack, `imem_req` stays high for exactly `TIMEOUT` cycles; `fetch_err` is high in the following cycle.

## Test plan
- **Reset / single fetch.** Hold `RST` = 0 two cycles, release. `fetch_start` pulse, ack one cycle later with `imem_rdata` = 32'h0800_0010 → `imem_addr` = 0; `IR` = 32'h0800_0010, `pc_out` = 4, `fetch_pc` = 0; `fetch_done` pulses once.
- **Jump load.** In IDLE, `pc_write` = 1, `PCSrc` = 10, `jump_target` = 32'h0000_0040 → `pc_out` = 32'h40 next cycle. Then fetch with ack after 3 wait cycles → `imem_addr` = 32'h40 throughout, `pc_out` = 32'h44.
- **Simultaneous start + write.** `fetch_start` and `pc_write` (`PCSrc` = 01, `branch_target` = 32'h100) in the same cycle → the request goes to 32'h100. `pc_write` asserted during WAIT → ignored, `pc_out` stays 32'h100 until the ack.
- **Misaligned load.** `PCSrc` = 11, `jr_target` = 32'h0000_0203 → `pc_out` = 32'h200, `align_fault` = 1 and still 1 after ten more fetches.
- **Timeout.** `TIMEOUT` = 8, never ack → `imem_req` high for 8 cycles, then one-cycle `fetch_err`; PC and `IR` unchanged. A subsequent normal fetch succeeds.
- **Reset mid-fetch / wrap.**
  - `RST` = 0 during WAIT → `imem_req` low next cycle; an ack 2 cycles later leaves `IR` = 0 and no `fetch_done`.
  - PC = 32'hFFFF_FFFC, fetch with ack → `pc_out` = 0.
